// File: rtl/lcd_bus_arbiter.sv
// Shares the HD44780 LCD bus between two single-write requesters after running power-on wait and init.
// Latency: ack pulses SETUP+E_HIGH+HOLD+exec cycles after the grant cycle; at least one IDLE cycle between transfers.
// Backpressure: a requester holds req until its ack; held requests wait through power-on, init and the other side's transfer.
//
// Ports:
//   clk, rst          : system clock, synchronous active-high reset
//   req0/rs0/data0    : requester 0 write request, register select, byte; ack0 pulses on completion
//   req1/rs1/data1    : requester 1, same as above; ack1 pulses on completion
//   rs, e, data       : LCD pins (all registered)
//   ready             : init sequence finished, sticky until reset
//   busy              : high in every state except IDLE
module lcd_bus_arbiter #(
  parameter int POWERON_CYC   = 2_000_000,
  parameter int SETUP_CYC     = 8,
  parameter int E_HIGH_CYC    = 40,
  parameter int HOLD_CYC      = 8,
  parameter int EXEC_CYC      = 5000,
  parameter int LONG_EXEC_CYC = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       rs,
  output logic       e,
  output logic [7:0] data,
  output logic       ready,
  output logic       busy
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CNT_MAX = max2(max2(max2(POWERON_CYC, SETUP_CYC), max2(E_HIGH_CYC, HOLD_CYC)),
                                max2(EXEC_CYC, LONG_EXEC_CYC));
  localparam int CW = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  // Terminal counts: a phase of N cycles runs with cnt = 0 .. N-1.
  localparam cnt_t PWR_LAST   = cnt_t'(POWERON_CYC - 1);
  localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYC - 1);
  localparam cnt_t EHI_LAST   = cnt_t'(E_HIGH_CYC - 1);
  localparam cnt_t HOLD_LAST  = cnt_t'(HOLD_CYC - 1);
  localparam cnt_t EXEC_LAST  = cnt_t'(EXEC_CYC - 1);
  localparam cnt_t LONG_LAST  = cnt_t'(LONG_EXEC_CYC - 1);

  typedef enum logic [2:0] {PWR_WAIT, INIT_LOAD, IDLE, SETUP, E_HI, HOLD, EXEC} state_t;

  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    return 8'h0C;  // display on, cursor off
      2'd2:    return 8'h06;  // increment, no shift
      default: return 8'h01;  // clear
    endcase
  endfunction

  state_t     state, state_nxt;
  cnt_t       cnt, cnt_nxt;
  logic [1:0] idx, idx_nxt;
  logic       last_grant, last_grant_nxt;
  logic       rs_nxt, e_nxt, ack0_nxt, ack1_nxt, ready_nxt, busy_nxt;
  logic [7:0] data_nxt;
  logic       long_cmd, grant0, grant1;
  cnt_t       exec_last;

  // Clear and home need the long execution wait; judged on the byte already on the bus.
  assign long_cmd  = !rs && (data == 8'h01 || data == 8'h02);
  assign exec_last = long_cmd ? LONG_LAST : EXEC_LAST;

  // On a tie, the requester that did not win last time goes first.
  assign grant0 = req0 && (!req1 || last_grant);
  assign grant1 = req1 && (!req0 || !last_grant);

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt + cnt_t'(1);
    idx_nxt        = idx;
    last_grant_nxt = last_grant;
    rs_nxt         = rs;
    data_nxt       = data;
    ready_nxt      = ready;

    unique case (state)
      PWR_WAIT: begin
        if (cnt == PWR_LAST) begin
          state_nxt = INIT_LOAD;
          cnt_nxt   = '0;
        end
      end
      INIT_LOAD: begin
        rs_nxt    = 1'b0;
        data_nxt  = init_rom(idx);
        state_nxt = SETUP;
        cnt_nxt   = '0;
      end
      IDLE: begin
        cnt_nxt = '0;
        if (grant0) begin
          rs_nxt         = rs0;
          data_nxt       = data0;
          last_grant_nxt = 1'b0;
          state_nxt      = SETUP;
        end else if (grant1) begin
          rs_nxt         = rs1;
          data_nxt       = data1;
          last_grant_nxt = 1'b1;
          state_nxt      = SETUP;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = E_HI;
          cnt_nxt   = '0;
        end
      end
      E_HI: begin
        if (cnt == EHI_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = EXEC;
          cnt_nxt   = '0;
        end
      end
      EXEC: begin
        if (cnt == exec_last) begin
          cnt_nxt = '0;
          if (ready) begin
            state_nxt = IDLE;
          end else begin
            // ready is low only while the init ROM is being played out
            idx_nxt = idx + 2'd1;
            if (idx == 2'd3) begin
              ready_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = INIT_LOAD;
            end
          end
        end
      end
      default: begin
        state_nxt = PWR_WAIT;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    e_nxt    = (state_nxt == E_HI);
    busy_nxt = (state_nxt != IDLE);
    ack0_nxt = ready && (state_nxt == EXEC) && (cnt_nxt == exec_last) && !last_grant_nxt;
    ack1_nxt = ready && (state_nxt == EXEC) && (cnt_nxt == exec_last) &&  last_grant_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PWR_WAIT;
      cnt        <= '0;
      idx        <= 2'd0;
      last_grant <= 1'b1;
      rs         <= 1'b0;
      e          <= 1'b0;
      data       <= 8'h00;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      last_grant <= last_grant_nxt;
      rs         <= rs_nxt;
      e          <= e_nxt;
      data       <= data_nxt;
      ack0       <= ack0_nxt;
      ack1       <= ack1_nxt;
      ready      <= ready_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed init/tie/long-command/reset steps plus randomized request rounds.
// Expected timing and arbitration order come from a transaction-level model (phase lengths summed, round-robin choice).
module tb_lcd_bus_arbiter;

  localparam int PW = 20;
  localparam int S  = 2;
  localparam int E  = 4;
  localparam int H  = 2;
  localparam int EX = 10;
  localparam int LG = 50;
  localparam int INIT_TOTAL = PW + 3 * (1 + S + E + H + EX) + (1 + S + E + H + LG);

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, rs0, ack0, req1, rs1, ack1;
  logic [7:0] data0, data1;
  logic       rs, e, ready, busy;
  logic [7:0] data;

  lcd_bus_arbiter #(
    .POWERON_CYC(PW), .SETUP_CYC(S), .E_HIGH_CYC(E), .HOLD_CYC(H),
    .EXEC_CYC(EX), .LONG_EXEC_CYC(LG)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
    .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
    .rs(rs), .e(e), .data(data), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int m_last = 1;  // model of the last granted requester

  logic [7:0] init_rom [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};

  // E-pulse and ack monitor, sampled on the falling edge.
  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         start;
    int         len;
  } pulse_t;

  pulse_t pq[$];
  pulse_t cur;
  logic   e_prev = 1'b0;
  int     ack0_cnt = 0;
  int     ack1_cnt = 0;

  always @(negedge clk) begin
    if (e === 1'b1) begin
      if (e_prev !== 1'b1) begin
        cur.rs    = rs;
        cur.d     = data;
        cur.start = cyc;
        cur.len   = 0;
      end
      cur.len = cur.len + 1;
    end else if (e_prev === 1'b1) begin
      pq.push_back(cur);
    end
    e_prev = e;
    if (ack0 === 1'b1) ack0_cnt++;
    if (ack1 === 1'b1) ack1_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int xfer_len(input logic r, input logic [7:0] d);
    return S + E + H + ((!r && (d == 8'h01 || d == 8'h02)) ? LG : EX);
  endfunction

  // Waits for ready after reset was released in cycle r; checks init pulses and absence of acks.
  task automatic init_check(input int r, output int rdy_cyc);
    int     a0b = ack0_cnt;
    int     a1b = ack1_cnt;
    logic   seen = 1'b0;
    pulse_t p;
    rdy_cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        seen    = 1'b1;
        rdy_cyc = cyc;
        break;
      end
    end
    chk("init_ready_seen", 32'(seen), 32'd1);
    chk("init_ready_cycle", rdy_cyc - r, INIT_TOTAL);
    chk("init_busy_low", 32'(busy), 32'd0);
    chk("init_pulse_count", pq.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (pq.size() > 0) begin
        p = pq.pop_front();
        chk("init_pulse_data", 32'(p.d), 32'(init_rom[i]));
        chk("init_pulse_rs", 32'(p.rs), 32'd0);
        chk("init_pulse_len", p.len, E);
        if (i == 0) chk("init_first_e_cycle", p.start - r, PW + 1 + S);
      end
    end
    pq.delete();
    chk("init_no_ack0", ack0_cnt - a0b, 32'd0);
    chk("init_no_ack1", ack1_cnt - a1b, 32'd0);
  endtask

  // One arbitration round starting from IDLE; each granted requester drops req the cycle after its ack.
  task automatic run_round(input logic r0, input logic s0, input logic [7:0] d0,
                           input logic r1, input logic s1, input logic [7:0] d1);
    int         order[$];
    int         g, a, who;
    logic       ok, g0, g1, sw;
    logic [7:0] dw;
    pulse_t     p;
    if (r0 && r1) begin
      if (m_last == 1) begin order.push_back(0); order.push_back(1); end
      else             begin order.push_back(1); order.push_back(0); end
    end else if (r0) order.push_back(0);
    else if (r1)     order.push_back(1);

    @(posedge clk); #1;
    req0 = r0; rs0 = s0; data0 = d0;
    req1 = r1; rs1 = s1; data1 = d1;
    g = cyc;
    foreach (order[k]) begin
      who = order[k];
      sw  = (who == 1) ? s1 : s0;
      dw  = (who == 1) ? d1 : d0;
      // Changing the winner's inputs after its grant must not reach the bus.
      @(posedge clk); #1;
      if (who == 0) begin rs0 = ~s0; data0 = ~d0; end
      else          begin rs1 = ~s1; data1 = ~d1; end
      ok = 1'b0; a = -1; g0 = 1'b0; g1 = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
          ok = 1'b1; a = cyc; g0 = ack0; g1 = ack1;
          break;
        end
      end
      chk("xfer_ack_seen", 32'(ok), 32'd1);
      chk("xfer_ack_cycle", a - g, xfer_len(sw, dw));
      chk("xfer_ack0", 32'(g0), 32'(who == 0));
      chk("xfer_ack1", 32'(g1), 32'(who == 1));
      chk("xfer_pulse_count", pq.size(), 32'd1);
      if (pq.size() > 0) begin
        p = pq.pop_front();
        chk("xfer_rs", 32'(p.rs), 32'(sw));
        chk("xfer_data", 32'(p.d), 32'(dw));
        chk("xfer_e_len", p.len, E);
        chk("xfer_e_start", p.start - g, S + 1);
      end
      m_last = who;
      @(posedge clk); #1;
      if (who == 0) req0 = 1'b0; else req1 = 1'b0;
      g = cyc;
      @(negedge clk);
      chk("gap_busy_low", 32'(busy), 32'd0);
      chk("ack_one_cycle", 32'({ack0, ack1}), 32'd0);
    end
  endtask

  initial begin
    int r, rdy, g;
    pulse_t p;
    rst = 1'b1;
    req0 = 1'b0; rs0 = 1'b0; data0 = 8'h00;
    req1 = 1'b0; rs1 = 1'b0; data1 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rs", 32'(rs), 32'd0);
    chk("rst_e", 32'(e), 32'd0);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_acks", 32'({ack0, ack1}), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    @(posedge clk); #1;
    rst = 1'b0;
    r = cyc;
    init_check(r, rdy);

    // Tie, round-robin: both held, twice.
    run_round(1'b1, 1'b1, 8'h30, 1'b1, 1'b1, 8'h31);
    run_round(1'b1, 1'b1, 8'h30, 1'b1, 1'b1, 8'h31);
    // Single data write.
    run_round(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    // Long (clear) and normal commands on requester 1.
    run_round(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01);
    run_round(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80);

    for (int k = 0; k < 12; k++) begin
      logic       r0, r1, s0, s1;
      logic [7:0] d0, d1;
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      s0 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin s0 = 1'b0; d0 = 8'($urandom_range(1, 2)); end
      if ($urandom_range(0, 3) == 0) begin s1 = 1'b0; d1 = 8'($urandom_range(1, 2)); end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_round(r0, s0, d0, r1, s1, d1);
    end

    // Request raised during power-on wait, then reset during E high.
    @(posedge clk); #1;
    rst = 1'b1;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = 1;
    r = cyc;
    init_check(r, rdy);
    g = rdy;  // first IDLE cycle is the grant cycle
    repeat (4) @(posedge clk);
    #1;
    chk("early_req_in_e_hi", cyc - g, 32'd4);
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("pre_rst_e_high", 32'(e), 32'd1);
    @(negedge clk);
    chk("rst_mid_e", 32'(e), 32'd0);
    chk("rst_mid_ready", 32'(ready), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd1);
    chk("rst_mid_ack0", 32'(ack0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    r = cyc;
    chk("abort_pulse_count", pq.size(), 32'd1);
    if (pq.size() > 0) begin
      p = pq.pop_front();
      chk("abort_pulse_data", 32'(p.d), 32'h55);
      chk("abort_pulse_rs", 32'(p.rs), 32'd1);
      chk("abort_pulse_start", p.start - g, S + 1);
      chk("abort_pulse_len", p.len, 32'd2);
    end
    pq.delete();
    init_check(r, rdy);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_reinit_idle", 32'(busy), 32'd0);
    chk("post_reinit_no_pulse", pq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
